// File: rtl/spdif_rate_scanner.sv
// spdif_rate_scanner
//   Rate-acquisition controller for the S/PDIF receive DAI. It holds the DAI in
//   reset, programs a candidate half-bit period, releases the DAI, and waits
//   for a run of samples whose L/R flag alternates. If that run arrives, the
//   rate is held as locked. Otherwise the watchdog expires, the next of the four
//   candidates is tried, and the scan continues. Losing lock retries the same
//   rate first.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   en_i               scan enable; 0 keeps the DAI in reset
//   dai_locked_i       DAI locked_o
//   dai_ack_i          DAI ack_o, one-cycle sample strobe
//   dai_lrck_i         DAI lrck_o, L/R flag of the strobed sample
//   clk_per_halfbit_o  half-bit period to the DAI; only changes while the DAI is in reset
//   dai_rst_o          reset to the DAI
//   rate_idx_o         current candidate index 0..3
//   locked_o           rate acquired
//   lost_o             one-cycle pulse when lock is lost
//   ack_o              dai_ack_i gated by locked_o (combinational)
//   force_i, force_idx_i  only with SPDIF_RATE_SCANNER_FORCE_EN: pin the candidate
//
// Handshake: dai_ack_i is a one-cycle strobe with no backpressure. ack_o
// forwards each strobe in the same cycle, but only while locked_o=1.
//
// Build option: define SPDIF_RATE_SCANNER_FORCE_EN to add the force ports.
module spdif_rate_scanner #(
  parameter int MAX_CLK_PER_HALFBIT_LOG2 = 5,
  parameter int CPH0                     = 8,
  parameter int CPH1                     = 9,
  parameter int CPH2                     = 4,
  parameter int CPH3                     = 16,
  parameter int SETTLE_CYCLES            = 64,
  parameter int TIMEOUT_LOG2             = 16,
  parameter int CONFIRM_SAMPLES          = 8
) (
  input  logic                                clk,
  input  logic                                rst,
`ifdef SPDIF_RATE_SCANNER_FORCE_EN
  input  logic                                force_i,
  input  logic [1:0]                          force_idx_i,
`endif
  input  logic                                en_i,
  input  logic                                dai_locked_i,
  input  logic                                dai_ack_i,
  input  logic                                dai_lrck_i,
  output logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit_o,
  output logic                                dai_rst_o,
  output logic [1:0]                          rate_idx_o,
  output logic                                locked_o,
  output logic                                lost_o,
  output logic                                ack_o
);

  localparam int CW = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CW-1:0] SETTLE_LAST    = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    CONFIRM_TARGET = 8'(CONFIRM_SAMPLES);

  typedef enum logic [1:0] {
    RST_DAI = 2'd0,
    SETTLE  = 2'd1,
    HUNT    = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  state_e                              state_q, state_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [TIMEOUT_LOG2-1:0]             timer_q, timer_d;
  logic [7:0]                          confirm_q, confirm_d;
  logic                                have_prev_q, have_prev_d;
  logic                                prev_lrck_q, prev_lrck_d;
  logic [1:0]                          rate_idx_q, rate_idx_d;
  logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] cph_q, cph_d;
  logic                                dai_rst_q, dai_rst_d;
  logic                                locked_q, locked_d;
  logic                                lost_q, lost_d;

  logic                                restart;
  logic                                sample_ok;
  logic [7:0]                          confirm_next;

`ifdef SPDIF_RATE_SCANNER_FORCE_EN
  logic                                force_q;
  logic [1:0]                          force_idx_q;
`endif

  function automatic logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] cph_of(input logic [1:0] idx);
    logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] v;
    v = MAX_CLK_PER_HALFBIT_LOG2'(CPH0);
    case (idx)
      2'd0:    v = MAX_CLK_PER_HALFBIT_LOG2'(CPH0);
      2'd1:    v = MAX_CLK_PER_HALFBIT_LOG2'(CPH1);
      2'd2:    v = MAX_CLK_PER_HALFBIT_LOG2'(CPH2);
      default: v = MAX_CLK_PER_HALFBIT_LOG2'(CPH3);
    endcase
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    confirm_d   = confirm_q;
    have_prev_d = have_prev_q;
    prev_lrck_d = prev_lrck_q;
    rate_idx_d  = rate_idx_q;
    lost_d      = 1'b0;
    restart     = 1'b0;

    sample_ok = dai_ack_i && dai_locked_i;
    // A repeated L/R flag breaks the run; that sample becomes the first of a new run.
    confirm_next = (!have_prev_q || (dai_lrck_i != prev_lrck_q)) ? confirm_q + 8'd1 : 8'd1;

    case (state_q)
      RST_DAI: begin
        if (cnt_q == CW'(1)) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SETTLE: begin
        timer_d     = '0;
        confirm_d   = '0;
        have_prev_d = 1'b0;
        if (cnt_q == SETTLE_LAST) begin
          state_d = HUNT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HUNT: begin
        timer_d = timer_q + TIMEOUT_LOG2'(1);
        if (sample_ok) begin
          confirm_d   = confirm_next;
          prev_lrck_d = dai_lrck_i;
          have_prev_d = 1'b1;
        end
        // Completing the confirmation outranks a simultaneous timeout.
        if (sample_ok && (confirm_next == CONFIRM_TARGET)) begin
          state_d = LOCKED;
          timer_d = '0;
        end else if (&timer_q) begin
          rate_idx_d = rate_idx_q + 2'd1;
          restart    = 1'b1;
        end
      end
      default: begin // LOCKED
        if (!dai_locked_i || (&timer_q)) begin
          lost_d  = 1'b1;
          restart = 1'b1;
        end else if (dai_ack_i) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMEOUT_LOG2'(1);
        end
      end
    endcase

`ifdef SPDIF_RATE_SCANNER_FORCE_EN
    // A pinned candidate overrides the scan advance; a new pin restarts the DAI.
    if (force_i) begin
      rate_idx_d = force_idx_i;
      if (!force_q || (force_idx_i != force_idx_q)) begin
        restart = 1'b1;
        lost_d  = (state_q == LOCKED);
      end
    end
`endif

    if (!en_i) begin
      restart = 1'b1;
      lost_d  = (state_q == LOCKED);
    end

    if (restart) begin
      state_d = RST_DAI;
      cnt_d   = '0;
    end
  end

  // Registered outputs follow the next state so they line up with it.
  // The period is loaded on the same edge that asserts the DAI reset.
  always_comb begin
    dai_rst_d = (state_d == RST_DAI);
    locked_d  = (state_d == LOCKED);
    cph_d     = (state_d == RST_DAI) ? cph_of(rate_idx_d) : cph_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_DAI;
      cnt_q       <= '0;
      timer_q     <= '0;
      confirm_q   <= '0;
      have_prev_q <= 1'b0;
      prev_lrck_q <= 1'b0;
      rate_idx_q  <= 2'd0;
      cph_q       <= MAX_CLK_PER_HALFBIT_LOG2'(CPH0);
      dai_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      confirm_q   <= confirm_d;
      have_prev_q <= have_prev_d;
      prev_lrck_q <= prev_lrck_d;
      rate_idx_q  <= rate_idx_d;
      cph_q       <= cph_d;
      dai_rst_q   <= dai_rst_d;
      locked_q    <= locked_d;
      lost_q      <= lost_d;
    end
  end

`ifdef SPDIF_RATE_SCANNER_FORCE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      force_q     <= 1'b0;
      force_idx_q <= 2'd0;
    end else begin
      force_q     <= force_i;
      force_idx_q <= force_idx_i;
    end
  end
`endif

  assign clk_per_halfbit_o = cph_q;
  assign dai_rst_o         = dai_rst_q;
  assign rate_idx_o        = rate_idx_q;
  assign locked_o          = locked_q;
  assign lost_o            = lost_q;
  assign ack_o             = dai_ack_i && locked_q;

endmodule

// File: tb/tb_spdif_rate_scanner.sv
// Bench for spdif_rate_scanner, built with a short settle time and watchdog so
// that full scan cycles fit in a short run.
module tb_spdif_rate_scanner;

  localparam int SETTLE  = 16;
  localparam int TLOG    = 10;
  localparam int TO      = 1 << TLOG;
  localparam int S       = 2 + SETTLE + TO;   // cycles per candidate when nothing locks
  localparam int CONFIRM = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dai_locked;
  logic       dai_ack;
  logic       dai_lrck;
  logic [4:0] cph;
  logic       dai_rst;
  logic [1:0] rate_idx;
  logic       locked_o;
  logic       lost_o;
  logic       ack_o;
`ifdef SPDIF_RATE_SCANNER_FORCE_EN
  logic       force_s = 1'b0;
  logic [1:0] force_idx = 2'd0;
`endif

  always #5 clk = ~clk;

  spdif_rate_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_LOG2  (TLOG)
  ) dut (
    .clk               (clk),
    .rst               (rst),
`ifdef SPDIF_RATE_SCANNER_FORCE_EN
    .force_i           (force_s),
    .force_idx_i       (force_idx),
`endif
    .en_i              (en),
    .dai_locked_i      (dai_locked),
    .dai_ack_i         (dai_ack),
    .dai_lrck_i        (dai_lrck),
    .clk_per_halfbit_o (cph),
    .dai_rst_o         (dai_rst),
    .rate_idx_o        (rate_idx),
    .locked_o          (locked_o),
    .lost_o            (lost_o),
    .ack_o             (ack_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst        = 1'b1;
    en         = 1'b1;
    dai_locked = 1'b0;
    dai_ack    = 1'b0;
    dai_lrck   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Ack scenario: lr_a[i] is the L/R flag of ack i, gap_a[i] the cycles until the next ack.
  bit lr_a  [0:31];
  int gap_a [0:31];
  int lock_at;

  task automatic fill_alt(input int n, input int gap, input bit first);
    for (int i = 0; i < n; i++) begin
      lr_a[i]  = first ^ i[0];
      gap_a[i] = gap;
    end
  endtask

  // Reference: lock happens on the first ack that completes a run of CONFIRM
  // consecutive alternating L/R flags.
  task automatic run_scn(input int n, input int start);
    int   run;
    logic exp_pre;
    logic exp_post;
    lock_at = -1;
    run     = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || lr_a[i] != lr_a[i-1]) run++;
      else run = 1;
      if (run == CONFIRM && lock_at < 0) lock_at = i;
    end
    dai_locked = 1'b1;
    dai_ack    = 1'b0;
    repeat (start) step();
    for (int i = 0; i < n; i++) begin
      exp_pre  = (lock_at >= 0) && (i > lock_at);
      exp_post = (lock_at >= 0) && (i >= lock_at);
      dai_ack  = 1'b1;
      dai_lrck = lr_a[i];
      #1;
      chk("ack_o gate", int'(ack_o), int'(exp_pre));
      step();
      dai_ack = 1'b0;
      chk("locked_o after ack", int'(locked_o), int'(exp_post));
      chk("lost_o quiet", int'(lost_o), 0);
      for (int k = 1; k < gap_a[i]; k++) begin
        step();
        chk("locked_o hold", int'(locked_o), int'(exp_post));
      end
    end
  endtask

  // ---------------- scan table ----------------
  typedef struct {
    int         cyc;
    logic       dai_rst;
    logic [1:0] rate;
    logic [4:0] cph;
  } scan_vec_t;

  scan_vec_t tbl [0:12];

  initial begin
    int j;
    tbl[0]  = '{1,       1'b1, 2'd0, 5'd8};
    tbl[1]  = '{2,       1'b0, 2'd0, 5'd8};
    tbl[2]  = '{S - 1,   1'b0, 2'd0, 5'd8};
    tbl[3]  = '{S,       1'b1, 2'd1, 5'd9};
    tbl[4]  = '{S + 1,   1'b1, 2'd1, 5'd9};
    tbl[5]  = '{S + 2,   1'b0, 2'd1, 5'd9};
    tbl[6]  = '{2*S,     1'b1, 2'd2, 5'd4};
    tbl[7]  = '{2*S + 2, 1'b0, 2'd2, 5'd4};
    tbl[8]  = '{3*S,     1'b1, 2'd3, 5'd16};
    tbl[9]  = '{3*S + 2, 1'b0, 2'd3, 5'd16};
    tbl[10] = '{4*S - 1, 1'b0, 2'd3, 5'd16};
    tbl[11] = '{4*S,     1'b1, 2'd0, 5'd8};
    tbl[12] = '{4*S + 2, 1'b0, 2'd0, 5'd8};

    // Reset values, with an ack present to show the gate is closed.
    rst = 1'b1; en = 1'b1; dai_locked = 1'b0; dai_ack = 1'b1; dai_lrck = 1'b0;
    step();
    step();
    chk("reset dai_rst", int'(dai_rst), 1);
    chk("reset cph", int'(cph), 8);
    chk("reset rate_idx", int'(rate_idx), 0);
    chk("reset locked", int'(locked_o), 0);
    chk("reset lost", int'(lost_o), 0);
    chk("reset ack_o", int'(ack_o), 0);
    rst = 1'b0; dai_ack = 1'b0;

    // Scan advance with silent DAI.
    j = 0;
    for (int cyc = 1; cyc <= 4*S + 2; cyc++) begin
      step();
      if (j < 13 && cyc == tbl[j].cyc) begin
        chk("scan dai_rst", int'(dai_rst), int'(tbl[j].dai_rst));
        chk("scan rate_idx", int'(rate_idx), int'(tbl[j].rate));
        chk("scan cph", int'(cph), int'(tbl[j].cph));
        chk("scan locked", int'(locked_o), 0);
        chk("scan lost", int'(lost_o), 0);
        j++;
      end
    end

    // Candidate 0: ack every 64 cycles, alternating L/R.
    restart();
    fill_alt(8, 64, 1'b0);
    run_scn(8, 20);
    chk("cand0 rate_idx", int'(rate_idx), 0);
    chk("cand0 cph", int'(cph), 8);
    chk("cand0 locked", int'(locked_o), 1);

    // Repeated L/R flag restarts the run; 7 more alternating acks needed.
    restart();
    fill_alt(14, 15, 1'b0);
    lr_a[6] = 1'b1;
    for (int i = 7; i < 14; i++) lr_a[i] = ~i[0];
    run_scn(14, 20);

    // Lock on candidate 2, then drop dai_locked_i.
    restart();
    fill_alt(8, 12, 1'b0);
    run_scn(8, 2*S + 20);
    chk("c2 rate_idx", int'(rate_idx), 2);
    chk("c2 locked", int'(locked_o), 1);
    dai_locked = 1'b0;
    step();
    chk("loss lost pulse", int'(lost_o), 1);
    chk("loss locked", int'(locked_o), 0);
    chk("loss dai_rst", int'(dai_rst), 1);
    chk("loss rate_idx", int'(rate_idx), 2);
    chk("loss cph", int'(cph), 4);
    step();
    chk("loss pulse width", int'(lost_o), 0);
    chk("loss dai_rst held", int'(dai_rst), 1);
    chk("loss cph held", int'(cph), 4);
    dai_ack = 1'b1;
    #1;
    chk("ack_o closed after loss", int'(ack_o), 0);
    dai_ack = 1'b0;
    // Same rate is retried first and relocks.
    run_scn(8, 20);
    chk("relock rate_idx", int'(rate_idx), 2);
    // Reset mid-lock: back to reset values, no loss pulse.
    rst = 1'b1;
    step();
    chk("midrst locked", int'(locked_o), 0);
    chk("midrst lost", int'(lost_o), 0);
    chk("midrst dai_rst", int'(dai_rst), 1);
    chk("midrst rate_idx", int'(rate_idx), 0);
    chk("midrst cph", int'(cph), 8);
    rst = 1'b0;

    // Ack watchdog in LOCKED.
    restart();
    fill_alt(8, 10, 1'b1);
    gap_a[7] = 1;
    run_scn(8, 20);
    repeat (TO - 1) step();
    chk("wdog still locked", int'(locked_o), 1);
    chk("wdog no early loss", int'(lost_o), 0);
    step();
    chk("wdog lost", int'(lost_o), 1);
    chk("wdog locked", int'(locked_o), 0);
    chk("wdog dai_rst", int'(dai_rst), 1);

    // Enable drop while locked.
    restart();
    fill_alt(8, 10, 1'b0);
    run_scn(8, 20);
    en = 1'b0;
    step();
    chk("en0 dai_rst", int'(dai_rst), 1);
    chk("en0 locked", int'(locked_o), 0);
    chk("en0 lost", int'(lost_o), 1);
    step();
    chk("en0 lost pulse width", int'(lost_o), 0);
    repeat (5) step();
    chk("en0 held in reset", int'(dai_rst), 1);
    en = 1'b1;
    step();
    chk("en1 rst cycle 2", int'(dai_rst), 1);
    step();
    chk("en1 released", int'(dai_rst), 0);

    // Random ack patterns against the run-length reference.
    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(4, 16);
      lr_a[0] = 1'($urandom_range(0, 1));
      gap_a[0] = $urandom_range(2, 40);
      for (int i = 1; i < n; i++) begin
        lr_a[i]  = ($urandom_range(0, 9) < 7) ? ~lr_a[i-1] : lr_a[i-1];
        gap_a[i] = $urandom_range(2, 40);
      end
      restart();
      run_scn(n, $urandom_range(20, 40));
      chk("rand rate_idx", int'(rate_idx), 0);
    end

`ifdef SPDIF_RATE_SCANNER_FORCE_EN
    force_s = 1'b1;
    force_idx = 2'd3;
    restart();
    for (int k = 0; k < 3*S + 100; k++) begin
      step();
      if (k % 500 == 250) chk("force rate pinned", int'(rate_idx), 3);
    end
    chk("force cph", int'(cph), 16);
    force_idx = 2'd1;
    step();
    chk("force change dai_rst", int'(dai_rst), 1);
    chk("force change rate", int'(rate_idx), 1);
    chk("force change cph", int'(cph), 9);
    force_s = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run can never hang.
  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
